// File: rtl/gps_sv_scheduler.sv
// Satellite sweep scheduler: walks the enabled slots of a small SV table, drives the
// L-code generator one SV at a time and returns one result (code or timeout) per slot.
module gps_sv_scheduler #(
  parameter int unsigned NSLOT   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     sys_clk_50,
  input  logic                     rst_n_in,
  input  logic                     cfg_we,
  input  logic [$clog2(NSLOT)-1:0] cfg_addr,
  input  logic [5:0]               cfg_sv,
  input  logic [NSLOT-1:0]         slot_en,
  input  logic                     sched_start,
  input  logic                     abort,
  output logic [5:0]               gps_sv_num,
  output logic                     gps_start_round,
  input  logic [127:0]             gps_l_code,
  input  logic                     gps_l_code_valid,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [5:0]               res_sv,
  output logic [127:0]             res_code,
  output logic                     res_timeout,
  output logic                     busy,
  output logic                     sweep_done
);

  localparam int unsigned AW = $clog2(NSLOT);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      table_q [NSLOT];
  logic [NSLOT-1:0] mask_q;
  logic [AW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            valid_prev_q;

  logic            first_found, next_found;
  logic [AW-1:0]   first_idx, next_idx;
  logic            accept, tmo, xfer;

  // Lowest slot enabled in the live mask, and next enabled slot above the pointer.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (slot_en[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = AW'(i);
      end
      if (mask_q[i] && (AW'(i) > ptr_q) && !next_found) begin
        next_found = 1'b1;
        next_idx   = AW'(i);
      end
    end
  end

  // Only a fresh low-to-high edge counts; a level already high on WAIT entry is ignored.
  assign accept = (state_q == S_WAIT) && gps_l_code_valid && !valid_prev_q;
  assign tmo    = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1)) && !accept;
  assign xfer   = (state_q == S_OUTPUT) && res_valid && res_ready;

  assign busy            = (state_q != S_IDLE);
  assign gps_start_round = (state_q == S_ISSUE) && !abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sched_start && !abort && first_found) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (accept || tmo) state_d = S_OUTPUT;
      S_OUTPUT: if (xfer) state_d = S_NEXT;
      S_NEXT:   state_d = next_found ? S_ISSUE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge sys_clk_50 or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge sys_clk_50 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < NSLOT; i++) table_q[i] <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      valid_prev_q <= 1'b0;
      gps_sv_num   <= '0;
      res_valid    <= 1'b0;
      res_sv       <= '0;
      res_code     <= '0;
      res_timeout  <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      valid_prev_q <= gps_l_code_valid;
      sweep_done   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_we && (32'(cfg_addr) < NSLOT)) table_q[cfg_addr] <= cfg_sv;
          if (sched_start && !abort) begin
            mask_q <= slot_en;
            if (first_found) begin
              ptr_q      <= first_idx;
              gps_sv_num <= table_q[first_idx];
            end else begin
              sweep_done <= 1'b1;
            end
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (accept) begin
            res_code    <= gps_l_code;
            res_sv      <= gps_sv_num;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
          end else if (tmo) begin
            res_code    <= '0;
            res_sv      <= gps_sv_num;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
          end
        end
        S_OUTPUT: if (xfer) res_valid <= 1'b0;
        S_NEXT: begin
          if (next_found) begin
            ptr_q      <= next_idx;
            gps_sv_num <= table_q[next_idx];
          end else begin
            sweep_done <= 1'b1;
          end
        end
        default: ;
      endcase
      // Abort overrides whatever the state above scheduled this cycle.
      if (abort && (state_q != S_IDLE)) begin
        res_valid  <= 1'b0;
        sweep_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gps_sv_scheduler.sv
// Directed bench for gps_sv_scheduler: instance a (TIMEOUT=64) for normal sweeps,
// instance b (TIMEOUT=16) for the timeout path; both share the stimulus.
module tb_gps_sv_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [5:0]   cfg_sv;
  logic [3:0]   slot_en;
  logic         sched_start, abort, res_ready;
  logic [127:0] l_code;
  logic         l_valid;

  logic         gen_on, gen_valid, man_valid;
  logic [127:0] gen_code, man_code;
  logic [5:0]   gsv;

  logic [5:0]   sv_a, rsv_a, sv_b, rsv_b;
  logic         sr_a, rv_a, rto_a, busy_a, done_a;
  logic         sr_b, rv_b, rto_b, busy_b, done_b;
  logic [127:0] rcode_a, rcode_b;

  int total = 0;
  int bad   = 0;

  assign l_valid = gen_valid | man_valid;
  assign l_code  = gen_valid ? gen_code : man_code;

  always #5 clk = ~clk;

  gps_sv_scheduler #(.NSLOT(4), .TIMEOUT(64)) dut_a (
    .sys_clk_50(clk), .rst_n_in(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sv(cfg_sv), .slot_en(slot_en), .sched_start(sched_start), .abort(abort),
    .gps_sv_num(sv_a), .gps_start_round(sr_a), .gps_l_code(l_code),
    .gps_l_code_valid(l_valid), .res_valid(rv_a), .res_ready(res_ready),
    .res_sv(rsv_a), .res_code(rcode_a), .res_timeout(rto_a), .busy(busy_a),
    .sweep_done(done_a)
  );

  gps_sv_scheduler #(.NSLOT(4), .TIMEOUT(16)) dut_b (
    .sys_clk_50(clk), .rst_n_in(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sv(cfg_sv), .slot_en(slot_en), .sched_start(sched_start), .abort(abort),
    .gps_sv_num(sv_b), .gps_start_round(sr_b), .gps_l_code(l_code),
    .gps_l_code_valid(l_valid), .res_valid(rv_b), .res_ready(res_ready),
    .res_sv(rsv_b), .res_code(rcode_b), .res_timeout(rto_b), .busy(busy_b),
    .sweep_done(done_b)
  );

  function automatic logic [127:0] mk(input logic [5:0] sv);
    mk = {8{sv, 10'h2A5}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; gen_on = 1'b0; man_valid = 1'b0; man_code = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sv = '0; slot_en = '0;
    sched_start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [5:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_sv = v;
    tick;
    cfg_we = 1'b0;
  endtask

  // Generator model: answers 20 cycles after each start pulse of instance a.
  initial begin
    gen_valid = 1'b0;
    gen_code  = '0;
    gsv       = '0;
    forever begin
      @(posedge clk); #2;
      if (gen_on && sr_a) begin
        gsv = sv_a;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #2;
        end
        if (gen_on) begin
          gen_valid = 1'b1;
          gen_code  = mk(gsv);
          @(posedge clk); #2;
          gen_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]   st_sv  [8];
    int           st_cyc [8];
    logic [5:0]   r_sv   [8];
    logic [127:0] r_code [8];
    logic         r_to   [8];
    int           r_cyc  [8];
    int ns, nr, nd, n, viol;
    logic [127:0] k;
    logic [5:0]   exp_sv [3];
    exp_sv[0] = 6'd3; exp_sv[1] = 6'd17; exp_sv[2] = 6'd9;

    // reset values
    rst_n = 1'b0; gen_on = 1'b0; man_valid = 1'b0; man_code = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sv = '0; slot_en = '0;
    sched_start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    #3;
    chk("rst_busy", busy_a, 0);
    chk("rst_res_valid", rv_a, 0);
    chk("rst_sv_num", sv_a, 0);
    chk("rst_start_round", sr_a, 0);
    chk("rst_res_code", rcode_a, 0);
    chk("rst_sweep_done", done_a, 0);
    do_reset;

    // three-slot sweep with generator answering
    cfg_write(0, 3); cfg_write(1, 17); cfg_write(2, 5); cfg_write(3, 9);
    slot_en = 4'b1011; res_ready = 1'b1; gen_on = 1'b1;
    sched_start = 1'b1;
    ns = 0; nr = 0; nd = 0;
    for (int i = 0; i < 150; i++) begin
      tick;
      if (i == 0) begin
        sched_start = 1'b0;
        chk("start_to_issue", sr_a, 1);
      end
      if (sr_a && ns < 8) begin st_sv[ns] = sv_a; st_cyc[ns] = i; ns++; end
      if (rv_a && nr < 8) begin
        r_sv[nr] = rsv_a; r_code[nr] = rcode_a; r_to[nr] = rto_a; r_cyc[nr] = i; nr++;
      end
      if (done_a) nd++;
    end
    chk("sweep_starts", ns, 3);
    chk("sweep_results", nr, 3);
    chk("sweep_done_cnt", nd, 1);
    chk("sweep_idle", busy_a, 0);
    for (int j = 0; j < 3; j++) begin
      if (j < ns) chk($sformatf("start_sv%0d", j), st_sv[j], exp_sv[j]);
      if (j < nr) begin
        chk($sformatf("res_sv%0d", j), r_sv[j], exp_sv[j]);
        chk($sformatf("res_code%0d", j), r_code[j], mk(exp_sv[j]));
        chk($sformatf("res_to%0d", j), r_to[j], 0);
      end
      if (j < ns && j < nr) chk($sformatf("latency%0d", j), r_cyc[j] - st_cyc[j], 21);
    end

    // timeout on instance b (TIMEOUT=16)
    do_reset;
    cfg_write(2, 42);
    slot_en = 4'b0100; res_ready = 1'b0;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    chk("to_issue", sr_b, 1);
    chk("to_issue_sv", sv_b, 42);
    tick;
    repeat (15) tick;
    chk("to_not_yet", rv_b, 0);
    tick;
    chk("to_valid", rv_b, 1);
    chk("to_flag", rto_b, 1);
    chk("to_code", rcode_b, 0);
    chk("to_sv", rsv_b, 42);
    res_ready = 1'b1;
    tick;
    chk("to_xfer", rv_b, 0);
    tick;
    chk("to_done", done_b, 1);
    chk("to_idle", busy_b, 0);

    // backpressure: ready low for 50 cycles
    do_reset;
    cfg_write(0, 7);
    slot_en = 4'b0001; gen_on = 1'b1;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    n = 0;
    while (!rv_a && n < 100) begin tick; n++; end
    chk("bp_got_result", rv_a, 1);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(rv_a === 1'b1 && rsv_a === 6'd7 && rcode_a === mk(6'd7) &&
            rto_a === 1'b0 && sr_a === 1'b0)) viol++;
      tick;
    end
    chk("bp_stable", viol, 0);
    res_ready = 1'b1;
    tick;
    chk("bp_xfer", rv_a, 0);
    gen_on = 1'b0;

    // valid stuck high before start must not be accepted
    do_reset;
    cfg_write(0, 11);
    slot_en = 4'b0001; man_valid = 1'b1;
    tick;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    repeat (10) tick;
    chk("stuck_not_acc", rv_a, 0);
    man_valid = 1'b0;
    tick;
    k = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    man_valid = 1'b1; man_code = k;
    tick;
    man_valid = 1'b0;
    chk("edge_acc", rv_a, 1);
    chk("edge_code", rcode_a, k);
    chk("edge_sv", rsv_a, 11);

    // abort during WAIT, with start and cfg write in the same cycle
    do_reset;
    cfg_write(0, 3); cfg_write(1, 17); cfg_write(2, 5); cfg_write(3, 9);
    slot_en = 4'b1010; res_ready = 1'b1; gen_on = 1'b1;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    chk("ab_first_sv", sv_a, 17);
    n = 0;
    while (!(sr_a && sv_a == 6'd9) && n < 100) begin tick; n++; end
    chk("ab_second_issue", sv_a, 9);
    gen_on = 1'b0;
    tick; tick;
    abort = 1'b1; sched_start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_sv = 6'd50;
    tick;
    abort = 1'b0; sched_start = 1'b0; cfg_we = 1'b0;
    chk("ab_idle", busy_a, 0);
    chk("ab_res_valid", rv_a, 0);
    chk("ab_no_done0", done_a, 0);
    tick;
    chk("ab_no_done1", done_a, 0);
    chk("ab_still_idle", busy_a, 0);
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    chk("ab_restart", sr_a, 1);
    chk("ab_restart_sv", sv_a, 17);

    // empty mask
    do_reset;
    slot_en = 4'b0000;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    chk("empty_done", done_a, 1);
    chk("empty_no_start", sr_a, 0);
    chk("empty_idle", busy_a, 0);
    tick;
    chk("empty_done_pulse", done_a, 0);

    // reset asserted while holding a result
    cfg_write(0, 5);
    slot_en = 4'b0001; gen_on = 1'b1; res_ready = 1'b0;
    sched_start = 1'b1;
    tick;
    sched_start = 1'b0;
    n = 0;
    while (!rv_a && n < 100) begin tick; n++; end
    chk("mr_result", rv_a, 1);
    gen_on = 1'b0;
    tick;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_res_valid", rv_a, 0);
    chk("mr_res_code", rcode_a, 0);
    chk("mr_res_sv", rsv_a, 0);
    chk("mr_sv_num", sv_a, 0);
    chk("mr_busy", busy_a, 0);
    chk("mr_res_to", rto_a, 0);
    #3 rst_n = 1'b1;
    tick;
    chk("mr_no_start", sr_a, 0);
    chk("mr_no_pending", rv_a, 0);
    chk("mr_idle", busy_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_sv_scheduler.md
GPS_SV_SCHEDULER -- requirements
Module: gps_sv_scheduler

Interface
REQ-001 Parameter NSLOT, default 4: number of satellite slots in the schedule table (2..16).
REQ-002 Parameter TIMEOUT, default 1024: max cycles to wait for code-generator valid per slot (≥4).
REQ-003 sys_clk_50  in  1  single clock; all state on its rising edge.
REQ-004 rst_n_in  in  1  asynchronous active-low reset.
REQ-005 cfg_we  in  1  slot-table write strobe.
REQ-006 cfg_addr  in  clog2(NSLOT)  slot index to write.
REQ-007 cfg_sv  in  6  SV number stored in the addressed slot.
REQ-008 slot_en  in  NSLOT  per-slot enable mask, sampled at sweep start.
REQ-009 sched_start  in  1  one-cycle pulse that starts a sweep.
REQ-010 abort  in  1  one-cycle pulse that cancels a sweep.
REQ-011 gps_sv_num  out  6  SV number driven to the code generator.
REQ-012 gps_start_round  out  1  round-start pulse to the code generator.
REQ-013 gps_l_code  in  128  L code from the generator.
REQ-014 gps_l_code_valid  in  1  generator L-code valid.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-016 res_sv  out  6  SV number of the held result.
REQ-017 res_code  out  128  captured L code; 0 on timeout.
REQ-018 res_timeout  out  1  held result timed out.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 sweep_done  out  1  one-cycle pulse at sweep completion.

Function
REQ-021 States: IDLE, ISSUE, WAIT, OUTPUT, NEXT; encoding is free.
REQ-022 cfg_we in IDLE writes cfg_sv into slot cfg_addr next edge; cfg_we while busy is ignored.
REQ-023 IDLE + sched_start: latch slot_en into mask_q, set slot pointer to lowest enabled slot, go to ISSUE; if mask is all zero, pulse sweep_done next cycle and stay IDLE.
REQ-024 ISSUE (exactly 1 cycle): gps_start_round=1, gps_sv_num=slot SV, clear timeout counter, go to WAIT.
REQ-025 gps_sv_num holds the current slot SV from ISSUE through OUTPUT; it holds its last value in IDLE.
REQ-026 WAIT accepts only a rising edge of gps_l_code_valid (registered previous value 0, current 1); a valid already high on WAIT entry is not accepted.
REQ-027 WAIT accept: capture gps_l_code into res_code, res_sv=slot SV, res_timeout=0, res_valid=1 next cycle, go to OUTPUT.
REQ-028 WAIT counter reaching TIMEOUT-1 with no accept: res_code=0, res_timeout=1, res_valid=1, go to OUTPUT; accept wins if it occurs in the same cycle.
REQ-029 OUTPUT: res_* stable while res_valid=1 and res_ready=0; transfer when both are high, then res_valid=0 and go to NEXT.
REQ-030 NEXT (1 cycle): advance to the next higher enabled slot in mask_q and go to ISSUE; if none remains, pulse sweep_done and go to IDLE.
REQ-031 abort in any non-IDLE state: next state IDLE, res_valid=0, gps_start_round=0, no sweep_done; abort with sched_start in the same cycle: abort wins and no sweep starts.
REQ-032 sched_start while busy is ignored.
REQ-033 Latency, enabled slot with no backpressure: start→ISSUE 1 cycle; generator valid edge→res_valid 1 cycle.

Reset
REQ-034 rst_n_in low: state=IDLE; slot table, mask_q, pointer, counter and every output=0, including gps_sv_num, res_code and sweep_done.
REQ-035 Reset deasserting mid-sweep leaves no pending result and no start pulse.

Verification
REQ-036 Slots {3,17,5,9}, slot_en=4'b1011, generator answers 20 cycles after each start → three start pulses with sv_num 3,17,9; results in that order with res_timeout=0; one sweep_done.
REQ-037 Generator never asserts valid, TIMEOUT=16, one slot enabled → res_valid exactly 16 cycles after WAIT entry; res_timeout=1; res_code=0.
REQ-038 res_ready held low for 50 cycles → res_* stable throughout, no new gps_start_round, transfer on the first ready cycle.
REQ-039 gps_l_code_valid stuck high before start → not accepted; a later low→high edge is accepted.
REQ-040 abort during WAIT, then sched_start with cfg_we → IDLE in 1 cycle, no sweep_done; new sweep restarts at the lowest enabled slot; cfg write ignored while busy.
REQ-041 slot_en=0 + sched_start → sweep_done the next cycle, no gps_start_round; rst_n_in pulsed mid-OUTPUT → all outputs 0 at once.
